pe_pos_feeder: RTL and testbench

Sequencer directly upstream of one `PE`. It reads home-cell offset packets and neighbour-cell position packets from the cell position caches and drives the PE's `home_offset`/`nb_pos` inputs. Home particles are streamed in batches of `NUM_FILTERS`. For each batch the block streams every particle of the home cell and all neighbour cells, stalling on dispatcher back-pressure. It then waits for the dispatcher buffer to drain before loading the next batch.

---
 rtl/pe_pos_feeder.sv | 191 +++++++++++++++++++
 tb/tb_pe_pos_feeder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_pos_feeder.sv
// pe_pos_feeder: sequences home-offset and neighbour-position cache reads into one PE,
// streaming one NUM_FILTERS batch of home particles against every cell per pass.
module pe_pos_feeder #(
  parameter int unsigned NUM_CELLS               = 14,
  parameter int unsigned CELL_SEL_WIDTH          = 4,
  parameter int unsigned RD_LATENCY              = 2,
  parameter int unsigned SKID_DEPTH              = 4,
  parameter int unsigned NUM_FILTERS             = 4,
  parameter int unsigned PARTICLE_ID_WIDTH       = 8,
  parameter int unsigned OFFSET_PKT_STRUCT_WIDTH = 16,
  parameter int unsigned POS_PKT_STRUCT_WIDTH    = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_start,
  input  logic [NUM_CELLS*PARTICLE_ID_WIDTH-1:0] i_cell_cnt,
  output logic [PARTICLE_ID_WIDTH-1:0]           o_home_rd_addr,
  output logic                                   o_home_rd_en,
  input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0]     i_home_rd_data,
  output logic [CELL_SEL_WIDTH-1:0]              o_nb_rd_cell,
  output logic [PARTICLE_ID_WIDTH-1:0]           o_nb_rd_addr,
  output logic                                   o_nb_rd_en,
  input  logic [POS_PKT_STRUCT_WIDTH-1:0]        i_nb_rd_data,
  output logic [OFFSET_PKT_STRUCT_WIDTH-1:0]     o_home_offset,
  output logic                                   o_home_offset_valid,
  output logic [POS_PKT_STRUCT_WIDTH-1:0]        o_nb_pos,
  output logic                                   o_nb_pos_valid,
  input  logic                                   i_disp_back_pressure,
  input  logic                                   i_disp_buf_empty,
  output logic                                   o_busy,
  output logic                                   o_done
);

  localparam int unsigned PW   = PARTICLE_ID_WIDTH;
  localparam int unsigned BW   = PARTICLE_ID_WIDTH + 1;
  localparam int unsigned PtrW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(SKID_DEPTH + 1);
  localparam int unsigned LatW = $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {StIdle, StLoadHome, StStreamNb, StDrain, StDone} state_e;

  state_e                    state_q, state_d;
  logic [PW-1:0]             cnt_q [NUM_CELLS];
  logic [PW-1:0]             cnt_d [NUM_CELLS];
  logic [BW-1:0]             batch_base_q, batch_base_d;
  logic [PW-1:0]             home_idx_q, home_idx_d;
  logic [CELL_SEL_WIDTH-1:0] cell_q, cell_d;
  logic [PW-1:0]             idx_q, idx_d;
  logic [RD_LATENCY-1:0]     home_pipe_q, home_pipe_d;
  logic [RD_LATENCY-1:0]     nb_pipe_q, nb_pipe_d;
  logic [POS_PKT_STRUCT_WIDTH-1:0] fifo_mem_q [SKID_DEPTH];
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]           fifo_cnt_q, fifo_cnt_d;
  logic                      done_q, done_d;

  logic            home_rd_en, nb_rd_en, home_last, credit_ok, fifo_push, fifo_pop;
  logic [PW-1:0]   cur_cnt;
  logic [BW-1:0]   home_next;
  logic [LatW-1:0] in_flight;

  assign cur_cnt   = cnt_q[cell_q];
  assign home_next = batch_base_q + BW'(home_idx_q) + BW'(1);
  assign home_last = (32'(home_idx_q) == NUM_FILTERS - 1) || (home_next == BW'(cnt_q[0]));

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + LatW'(nb_pipe_q[i]);
  end

  // Outstanding reads plus buffered packets can never exceed the skid depth.
  assign credit_ok = (32'(fifo_cnt_q) + 32'(in_flight)) < SKID_DEPTH;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    batch_base_d = batch_base_q;
    home_idx_d   = home_idx_q;
    cell_d       = cell_q;
    idx_d        = idx_q;
    home_rd_en   = 1'b0;
    nb_rd_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          for (int k = 0; k < NUM_CELLS; k++) cnt_d[k] = i_cell_cnt[k*PW +: PW];
          batch_base_d = '0;
          home_idx_d   = '0;
          state_d      = (i_cell_cnt[PW-1:0] == '0) ? StDone : StLoadHome;
        end
      end
      StLoadHome: begin
        home_rd_en = 1'b1;
        if (home_last) begin
          state_d = StStreamNb;
          cell_d  = '0;
          idx_d   = '0;
        end else begin
          home_idx_d = home_idx_q + 1'b1;
        end
      end
      StStreamNb: begin
        nb_rd_en = (cur_cnt != '0) && credit_ok;
        // An empty cell takes the advance path directly, costing one cycle and no read.
        if ((cur_cnt == '0) || (nb_rd_en && (idx_q == cur_cnt - 1'b1))) begin
          idx_d = '0;
          if (32'(cell_q) == NUM_CELLS - 1) state_d = StDrain;
          else                              cell_d  = cell_q + 1'b1;
        end else if (nb_rd_en) begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDrain: begin
        if ((fifo_cnt_q == '0) && (in_flight == '0) && i_disp_buf_empty) begin
          batch_base_d = batch_base_q + BW'(NUM_FILTERS);
          home_idx_d   = '0;
          state_d      = (batch_base_d < BW'(cnt_q[0])) ? StLoadHome : StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    home_pipe_d[0] = home_rd_en;
    nb_pipe_d[0]   = nb_rd_en;
    for (int i = 1; i < RD_LATENCY; i++) begin
      home_pipe_d[i] = home_pipe_q[i-1];
      nb_pipe_d[i]   = nb_pipe_q[i-1];
    end
  end

  assign fifo_push = nb_pipe_q[RD_LATENCY-1];
  assign fifo_pop  = o_nb_pos_valid;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_push) wr_ptr_d = (32'(wr_ptr_q) == SKID_DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
    if (fifo_pop)  rd_ptr_d = (32'(rd_ptr_q) == SKID_DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
    fifo_cnt_d = fifo_cnt_q + CntW'(fifo_push) - CntW'(fifo_pop);
    done_d     = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      for (int k = 0; k < NUM_CELLS; k++) cnt_q[k] <= '0;
      batch_base_q <= '0;
      home_idx_q   <= '0;
      cell_q       <= '0;
      idx_q        <= '0;
      home_pipe_q  <= '0;
      nb_pipe_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      batch_base_q <= batch_base_d;
      home_idx_q   <= home_idx_d;
      cell_q       <= cell_d;
      idx_q        <= idx_d;
      home_pipe_q  <= home_pipe_d;
      nb_pipe_q    <= nb_pipe_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem_q[wr_ptr_q] <= i_nb_rd_data;
  end

  assign o_home_rd_en        = home_rd_en;
  assign o_home_rd_addr      = home_rd_en ? PW'(batch_base_q + BW'(home_idx_q)) : '0;
  assign o_nb_rd_en          = nb_rd_en;
  assign o_nb_rd_cell        = nb_rd_en ? cell_q : '0;
  assign o_nb_rd_addr        = nb_rd_en ? idx_q : '0;
  assign o_home_offset_valid = home_pipe_q[RD_LATENCY-1];
  assign o_home_offset       = o_home_offset_valid ? i_home_rd_data : '0;
  assign o_nb_pos_valid      = (fifo_cnt_q != '0) && !i_disp_back_pressure;
  assign o_nb_pos            = o_nb_pos_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign o_busy              = (state_q != StIdle);
  assign o_done              = done_q;

endmodule

// File: tb/tb_pe_pos_feeder.sv
// Bench for pe_pos_feeder: latency-accurate cache models feed the DUT, and a queue model of
// the expected home/neighbour packet order is checked every cycle.
module tb_pe_pos_feeder;
  localparam int unsigned NC = 14, PW = 8, CW = 4, L = 2, SD = 4, NF = 4, OW = 16, SW = 16;

  logic           clk = 1'b0, rst = 1'b1, i_start = 1'b0;
  logic [NC*PW-1:0] i_cell_cnt = '0;
  logic [PW-1:0]  o_home_rd_addr, o_nb_rd_addr;
  logic           o_home_rd_en, o_nb_rd_en, o_home_offset_valid, o_nb_pos_valid, o_busy, o_done;
  logic [CW-1:0]  o_nb_rd_cell;
  logic [OW-1:0]  i_home_rd_data, o_home_offset;
  logic [SW-1:0]  i_nb_rd_data, o_nb_pos;
  logic           i_disp_back_pressure = 1'b0, i_disp_buf_empty = 1'b1;

  always #5 clk = ~clk;

  pe_pos_feeder #(
    .NUM_CELLS(NC), .CELL_SEL_WIDTH(CW), .RD_LATENCY(L), .SKID_DEPTH(SD), .NUM_FILTERS(NF),
    .PARTICLE_ID_WIDTH(PW), .OFFSET_PKT_STRUCT_WIDTH(OW), .POS_PKT_STRUCT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_cell_cnt(i_cell_cnt),
    .o_home_rd_addr(o_home_rd_addr), .o_home_rd_en(o_home_rd_en),
    .i_home_rd_data(i_home_rd_data), .o_nb_rd_cell(o_nb_rd_cell),
    .o_nb_rd_addr(o_nb_rd_addr), .o_nb_rd_en(o_nb_rd_en), .i_nb_rd_data(i_nb_rd_data),
    .o_home_offset(o_home_offset), .o_home_offset_valid(o_home_offset_valid),
    .o_nb_pos(o_nb_pos), .o_nb_pos_valid(o_nb_pos_valid),
    .i_disp_back_pressure(i_disp_back_pressure), .i_disp_buf_empty(i_disp_buf_empty),
    .o_busy(o_busy), .o_done(o_done)
  );

  function automatic logic [OW-1:0] home_data(input logic [PW-1:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  function automatic logic [SW-1:0] nb_data(input logic [CW-1:0] c, input logic [PW-1:0] a);
    return {c, 4'h9, a};
  endfunction

  // Cache models: data appears exactly L cycles after the read enable, junk otherwise.
  logic [L-1:0]  hp_v = '0, np_v = '0;
  logic [PW-1:0] hp_a [L];
  logic [PW-1:0] np_a [L];
  logic [CW-1:0] np_c [L];
  always @(posedge clk) begin
    hp_v    <= {hp_v[L-2:0], o_home_rd_en};
    np_v    <= {np_v[L-2:0], o_nb_rd_en};
    hp_a[0] <= o_home_rd_addr;
    np_a[0] <= o_nb_rd_addr;
    np_c[0] <= o_nb_rd_cell;
    for (int i = 1; i < L; i++) begin
      hp_a[i] <= hp_a[i-1];
      np_a[i] <= np_a[i-1];
      np_c[i] <= np_c[i-1];
    end
  end
  assign i_home_rd_data = hp_v[L-1] ? home_data(hp_a[L-1]) : 16'hDEAD;
  assign i_nb_rd_data   = np_v[L-1] ? nb_data(np_c[L-1], np_a[L-1]) : 16'hBEEF;

  typedef struct packed { logic [15:0] d; int need; } exp_t;
  exp_t exp_home[$];
  exp_t exp_nb[$];
  exp_t e;
  int   cnt_m [NC];
  int   checks = 0, errors = 0, cyc = 0, start_cyc = 0, rel;
  int   home_got, nb_got, nb_issued, home_phases, home_rd_seen, exp_home_tot, exp_nb_tot;
  int   first_home_rel, last_home_rel, first_nbrd_rel, first_nbv_rel, last_nbv_rel;
  int   done_rel, done_cnt;
  bit   checking = 0, prev_home_en = 0, prev_be = 1;
  bit   bp_rand = 0, bp_force = 0, be_rand = 0, be_force = 0, be_val = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #2;
      i_disp_back_pressure = bp_force ? 1'b1 : (bp_rand ? ($urandom_range(0, 3) == 0) : 1'b0);
      i_disp_buf_empty = be_force ? be_val : (be_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      rel = cyc - start_cyc;
      if (o_home_offset_valid) begin
        if (exp_home.size() == 0) chk("home_unexpected", 1, 0);
        else begin
          e = exp_home.pop_front();
          chk("home_data", o_home_offset, e.d);
          chk("home_after_prev_stream", nb_got >= e.need, 1);
        end
        home_got++;
        if (first_home_rel < 0) first_home_rel = rel;
        last_home_rel = rel;
      end
      if (o_nb_pos_valid) begin
        chk("nb_valid_under_bp", i_disp_back_pressure, 0);
        if (exp_nb.size() == 0) chk("nb_unexpected", 1, 0);
        else begin
          e = exp_nb.pop_front();
          chk("nb_data", o_nb_pos, e.d);
          chk("nb_after_home_batch", home_got >= e.need, 1);
        end
        nb_got++;
        if (first_nbv_rel < 0) first_nbv_rel = rel;
        last_nbv_rel = rel;
      end
      if (o_nb_rd_en) begin
        nb_issued++;
        if (first_nbrd_rel < 0) first_nbrd_rel = rel;
        chk("skid_bound", (nb_issued - nb_got) <= SD, 1);
      end
      if (o_home_rd_en) begin
        if (!prev_home_en) begin
          home_phases++;
          if (home_rd_seen > 0) chk("reload_needs_buf_empty", prev_be, 1);
        end
        home_rd_seen++;
      end
      if (o_done) begin
        done_cnt++;
        if (done_rel < 0) done_rel = rel;
      end
      prev_home_en = o_home_rd_en;
      prev_be      = i_disp_buf_empty;
    end
  end

  task automatic start_pass();
    int   home, per, n;
    exp_t t;
    exp_home.delete();
    exp_nb.delete();
    home_got = 0; nb_got = 0; nb_issued = 0; home_phases = 0; home_rd_seen = 0;
    first_home_rel = -1; last_home_rel = -1; first_nbrd_rel = -1; first_nbv_rel = -1;
    last_nbv_rel = -1; done_rel = -1; done_cnt = 0; prev_home_en = 0;
    home = cnt_m[0];
    per  = 0;
    for (int c = 0; c < NC; c++) per += cnt_m[c];
    for (int b = 0; b * NF < home; b++) begin
      n = (home - b * NF < NF) ? home - b * NF : NF;
      for (int i = 0; i < n; i++) begin
        t.d = home_data(8'(b * NF + i)); t.need = b * per; exp_home.push_back(t);
      end
      for (int c = 0; c < NC; c++)
        for (int i = 0; i < cnt_m[c]; i++) begin
          t.d = nb_data(4'(c), 8'(i)); t.need = b * NF + n; exp_nb.push_back(t);
        end
    end
    exp_home_tot = exp_home.size();
    exp_nb_tot   = exp_nb.size();
    checking = 1;
    @(posedge clk); #1;
    for (int c = 0; c < NC; c++) i_cell_cnt[c*PW +: PW] = 8'(cnt_m[c]);
    i_start   = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_nb(input int n, input int budget);
    int k = 0;
    while (nb_got < n && k < budget) begin @(posedge clk); k++; end
    #1;
    chk("wait_nb_progress", nb_got >= n, 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin @(posedge clk); k++; end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_done_once"}, done_cnt, 1);
    chk({name, "_home_left"}, exp_home.size(), 0);
    chk({name, "_nb_left"}, exp_nb.size(), 0);
    chk({name, "_home_total"}, home_got, exp_home_tot);
    chk({name, "_nb_total"}, nb_got, exp_nb_tot);
    chk({name, "_idle"}, o_busy, 0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ctrl"}, {o_home_rd_en, o_nb_rd_en, o_home_offset_valid, o_nb_pos_valid,
                          o_busy, o_done}, 0);
    chk({name, "_data"}, {o_home_offset, o_nb_pos}, 0);
    chk({name, "_addr"}, {o_home_rd_addr, o_nb_rd_addr, o_nb_rd_cell}, 0);
  endtask

  initial begin
    int sum, t0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Single batch, dispatcher buffer held non-empty until the stream is over.
    cnt_m[0] = 3;
    for (int c = 1; c < NC; c++) cnt_m[c] = 2;
    be_force = 1; be_val = 0;
    start_pass();
    wait_nb(29, 300);
    repeat (5) @(posedge clk);
    #1;
    chk("s1_waits_buf_empty_busy", o_busy, 1);
    chk("s1_waits_buf_empty_done", done_cnt, 0);
    be_force = 0;
    wait_done("s1", 100);
    chk("s1_first_home_valid", first_home_rel, 3);
    chk("s1_last_home_valid", last_home_rel, 5);
    chk("s1_first_nb_read", first_nbrd_rel, 4);
    chk("s1_first_nb_valid", first_nbv_rel, 7);
    chk("s1_nb_contiguous", last_nbv_rel - first_nbv_rel, 28);
    chk("s1_nb_count", nb_got, 29);

    // Two batches: NUM_FILTERS then one home particle.
    be_rand = 1;
    cnt_m[0] = NF + 1;
    sum = NF + 1;
    for (int c = 1; c < NC; c++) begin cnt_m[c] = $urandom_range(0, 3); sum += cnt_m[c]; end
    start_pass();
    wait_done("s2", 2000);
    chk("s2_home_phases", home_phases, 2);
    chk("s2_home_count", home_got, NF + 1);
    chk("s2_nb_count", nb_got, 2 * sum);

    // Ten-cycle back-pressure window in mid-stream.
    be_rand = 0;
    for (int c = 0; c < NC; c++) cnt_m[c] = 3;
    start_pass();
    wait_nb(5, 200);
    @(posedge clk); #1;
    bp_force = 1;
    t0 = nb_got;
    repeat (10) @(posedge clk);
    #1;
    chk("s3_no_output_under_bp", nb_got, t0);
    bp_force = 0;
    bp_rand  = 1;
    wait_done("s3", 1000);

    // Empty cells 2, 5 and 13 are skipped.
    be_rand = 1;
    cnt_m[0] = 2;
    sum = 2;
    for (int c = 1; c < NC; c++) begin
      cnt_m[c] = (c == 2 || c == 5 || c == 13) ? 0 : $urandom_range(1, 3);
      sum += cnt_m[c];
    end
    start_pass();
    wait_done("s4", 1000);
    chk("s4_nb_count", nb_got, sum);

    // Home count 0: immediate done, no reads.
    bp_rand = 0;
    cnt_m[0] = 0;
    start_pass();
    wait_done("s5", 20);
    chk("s5_done_cycle", done_rel, 2);
    chk("s5_no_home_reads", home_rd_seen, 0);
    chk("s5_no_nb_reads", nb_issued, 0);

    // Reset in mid-stream, then a clean pass with an ignored start while busy.
    be_rand = 0;
    cnt_m[0] = 4;
    for (int c = 1; c < NC; c++) cnt_m[c] = 3;
    start_pass();
    wait_nb(10, 300);
    checking = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("s6_after_rst");
    cnt_m[0] = 6;
    for (int c = 1; c < NC; c++) cnt_m[c] = $urandom_range(0, 2);
    start_pass();
    @(posedge clk); #1;
    chk("s6_busy_before_restart", o_busy, 1);
    for (int c = 0; c < NC; c++) i_cell_cnt[c*PW +: PW] = 8'd1;
    i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    wait_done("s6", 1500);

    // Random passes with random back-pressure and buffer-empty behaviour.
    bp_rand = 1;
    be_rand = 1;
    for (int p = 0; p < 4; p++) begin
      cnt_m[0] = $urandom_range(0, 9);
      for (int c = 1; c < NC; c++) cnt_m[c] = $urandom_range(0, 3);
      start_pass();
      wait_done("rand", 3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
